btn_scan_ctrl: RTL and testbench
================================

BTN_SCAN_CTRL -- requirements
Module: btn_scan_ctrl

Interface
REQ-001 Parameter N_BTN, default 4: number of buttons sharing one sample scheduler; legal range 2..8.
REQ-002 Parameter TICK_W, default 21: tick counter width; one sample tick every 2^TICK_W clocks.
REQ-003 Parameter SAMPLES, default 3: consecutive agreeing samples needed to change state; legal range 2..7.
REQ-004 Port clock  in  1: single clock; all state updates on its rising edge.
REQ-005 Port reset_n  in  1: reset, asynchronous assert, active-low.
REQ-006 Port en  in  1: scan enable; when 0, all scanning state freezes.
REQ-007 Port btn_raw  in  N_BTN: asynchronous raw button inputs.
REQ-008 Port level  out  N_BTN: debounced stable level per button.
REQ-009 Port press  out  N_BTN: one-clock pulse on a debounced 0->1 transition.
REQ-010 Port release  out  N_BTN: one-clock pulse on a debounced 1->0 transition.
REQ-011 Port scan_idx  out  clog2(N_BTN): index of the button sampled at the next tick.

Function
REQ-012 Each btn_raw bit SHALL pass through a two-flop synchronizer; only synchronized values are sampled.
REQ-013 Tick counter (TICK_W bits) SHALL increment every clock with en=1 and wrap naturally; tick asserts when the counter equals all-ones.
REQ-014 On tick, only button scan_idx SHALL be sampled; scan_idx then increments, wrapping N_BTN-1 -> 0.
REQ-015 Each button SHALL therefore be sampled once every N_BTN*2^TICK_W clocks.
REQ-016 Per-button FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO, with a 3-bit agree counter.
REQ-017 STABLE_LO: sample 1 -> WAIT_HI, cnt=1; sample 0 -> stay.
REQ-018 WAIT_HI: sample 1 -> cnt+1; when cnt+1 == SAMPLES -> STABLE_HI, cnt=0; sample 0 -> STABLE_LO, cnt=0.
REQ-019 STABLE_HI, WAIT_LO: mirror REQ-017/018 with polarity swapped; completion -> STABLE_LO.
REQ-020 level[i] SHALL be 1 exactly in STABLE_HI and WAIT_LO.
REQ-021 press[i] / release[i] SHALL assert for one clock, registered, in the same cycle as level[i] changes, which is the clock after the completing tick.
REQ-022 press and release SHALL never assert together for one button; at most one button pulses per clock.
REQ-023 en=0 SHALL hold the tick counter, scan_idx and all FSM states; press and release forced 0; synchronizers keep running.
REQ-024 A raw glitch shorter than one sample period between ticks of its button SHALL have no effect.

Reset
REQ-025 reset_n low SHALL asynchronously clear the tick counter, scan_idx, synchronizers, counters, level, press and release to 0; all FSMs go to STABLE_LO.
REQ-026 A reset asserted mid-WAIT SHALL discard the partial count; no pulse is emitted on reset exit.
REQ-027 Release of reset SHALL be synchronized internally by the integrator; the block relies only on the rising edge of reset_n being synchronous to clock.

Structure
REQ-028 Shared package btn_pkg SHALL hold the FSM state typedef (2-bit encoding) and default parameter constants.
REQ-029 Per-button logic SHALL be one sub-module, btn_db_fsm (sample_en, sample, level, press, release), instantiated N_BTN times.
REQ-030 The tick counter, scan pointer and synchronizers SHALL live in btn_scan_ctrl.
REQ-031 The block SHALL contain no latches and no combinational path from btn_raw to any output.

Verification (TICK_W=4, N_BTN=4, SAMPLES=3)
REQ-032 Reset, then btn_raw=0 for 1000 clocks -> level=0, no pulses; scan_idx cycles 0,1,2,3,0 every 16 clocks.
REQ-033 btn_raw[0]=1 held -> press[0] is a single one-clock pulse and level[0]=1 after the third consecutive button-0 tick (about 3*64 clocks); then release on 0 after 3 further button-0 ticks.
REQ-034 btn_raw[2] toggled every 5 clocks for 500 clocks -> no press[2] or release[2]; level[2] stays 0.
REQ-035 btn_raw[1] high for 2 button-1 ticks, low on the 3rd, high again -> no pulse until 3 fresh agreeing samples.
REQ-036 en=0 for 200 clocks during WAIT_HI -> counter and scan_idx frozen; the pattern resumes exactly on en=1.
REQ-037 Assert reset_n=0 mid-WAIT_HI for button 3 -> outputs clear immediately; after release, button 3 needs 3 new agreeing samples.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: debounce FSM state type and default scanner parameters
package btn_pkg;
  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} db_state_e;
  localparam int N_BTN_DEF   = 4;
  localparam int TICK_W_DEF  = 21;
  localparam int SAMPLES_DEF = 3;
endpackage

// File: rtl/btn_db_fsm.sv
// btn_db_fsm: per-button debouncer, advances only on its sample_en strobe
module btn_db_fsm
  import btn_pkg::*;
#(
  parameter int SAMPLES = SAMPLES_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sample_en,
  input  logic sample,
  output logic level,
  output logic press,
  output logic rel
);
  db_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d, cnt_inc;
  logic press_q, press_d, rel_q, rel_d, done;
  assign cnt_inc = cnt_q + 3'd1;
  assign done    = cnt_inc == 3'(SAMPLES);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (sample_en)
      case (state_q)
        STABLE_LO: if (sample) begin
          state_d = WAIT_HI;
          cnt_d   = 3'd1;
        end
        WAIT_HI: if (!sample) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (done) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          press_d = 1'b1;
        end else cnt_d = cnt_inc;
        STABLE_HI: if (!sample) begin
          state_d = WAIT_LO;
          cnt_d   = 3'd1;
        end
        WAIT_LO: if (sample) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (done) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else cnt_d = cnt_inc;
        default: state_d = STABLE_LO;
      endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  assign level = (state_q == STABLE_HI) || (state_q == WAIT_LO);
  assign press = press_q;
  assign rel   = rel_q;
endmodule

// File: rtl/btn_scan_ctrl.sv
// btn_scan_ctrl: shared tick scheduler sampling one synchronized button per tick
module btn_scan_ctrl
  import btn_pkg::*;
#(
  parameter int N_BTN   = N_BTN_DEF,
  parameter int TICK_W  = TICK_W_DEF,
  parameter int SAMPLES = SAMPLES_DEF
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       en,
  input  logic [N_BTN-1:0]           btn_raw,
  output logic [N_BTN-1:0]           level,
  output logic [N_BTN-1:0]           press,
  output logic [N_BTN-1:0]           rel,
  output logic [$clog2(N_BTN)-1:0]   scan_idx
);
  localparam int IDX_W = $clog2(N_BTN);
  logic [N_BTN-1:0] sync1_q, sync2_q, press_raw, rel_raw, sample_en;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic tick;
  assign tick = en && (&tick_q);
  always_comb begin
    tick_d = en ? tick_q + TICK_W'(1) : tick_q;
    idx_d  = !tick ? idx_q : (idx_q == IDX_W'(N_BTN - 1)) ? '0 : idx_q + IDX_W'(1);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      tick_q  <= '0;
      idx_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
    end
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    assign sample_en[i] = tick && (idx_q == IDX_W'(i));
    btn_db_fsm #(.SAMPLES(SAMPLES)) u_fsm (
      .clock     (clock),
      .reset_n   (reset_n),
      .sample_en (sample_en[i]),
      .sample    (sync2_q[i]),
      .level     (level[i]),
      .press     (press_raw[i]),
      .rel       (rel_raw[i])
    );
  end
  // pulses already registered; en only masks them while scanning is frozen
  assign press    = en ? press_raw : '0;
  assign rel      = en ? rel_raw : '0;
  assign scan_idx = idx_q;
endmodule

// File: tb/tb_btn_scan_ctrl.sv
// tb_btn_scan_ctrl: scoreboard bench with a sample-history reference model
module tb_btn_scan_ctrl;
  localparam int NB = 4, TW = 4, NS = 3, TP = 1 << TW;
  typedef struct {int at; logic [NB-1:0] p; logic [NB-1:0] r;} evt_t;
  logic clock = 1'b0, reset_n = 1'b0, en = 1'b1;
  logic [NB-1:0] btn_raw = '0, level, press, rel;
  logic [1:0] scan_idx;
  btn_scan_ctrl #(.N_BTN(NB), .TICK_W(TW), .SAMPLES(NS)) dut (
    .clock(clock), .reset_n(reset_n), .en(en), .btn_raw(btn_raw),
    .level(level), .press(press), .rel(rel), .scan_idx(scan_idx)
  );
  always #5 clock = ~clock;
  int nchk = 0, nfail = 0, edges = 0, ecnt = 0;
  int run[NB] = '{default: 0};
  int press_cnt[NB] = '{default: 0};
  int rel_cnt[NB] = '{default: 0};
  logic [NB-1:0] lev = '0;
  logic [NB-1:0] hist[2] = '{default: '0};
  evt_t sbq[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a button flips once NS consecutive samples of it disagree with its level
  initial begin
    logic [NB-1:0] smp, oh;
    int b;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        run = '{default: 0};
        hist = '{default: '0};
        lev = '0;
        ecnt = 0;
        sbq.delete();
      end else begin
        edges++;
        smp = hist[0];
        hist[0] = hist[1];
        hist[1] = btn_raw;
        if (en) begin
          if (ecnt % TP == TP - 1) begin
            b = (ecnt / TP) % NB;
            if (smp[b] == lev[b]) run[b] = 0;
            else begin
              run[b]++;
              if (run[b] == NS) begin
                run[b] = 0;
                lev[b] = ~lev[b];
                oh = '0;
                oh[b] = 1'b1;
                sbq.push_back('{edges, lev[b] ? oh : '0, lev[b] ? '0 : oh});
              end
            end
          end
          ecnt++;
        end
      end
    end
  end

  initial begin
    evt_t e;
    logic [NB-1:0] ep, er;
    forever begin
      @(negedge clock);
      ep = '0;
      er = '0;
      if (sbq.size() > 0 && sbq[0].at == edges) begin
        e = sbq.pop_front();
        if (en) begin
          ep = e.p;
          er = e.r;
        end
      end
      chk("press", 32'(press), 32'(ep));
      chk("release", 32'(rel), 32'(er));
      chk("one_pulse", 32'($countones(press | rel) <= 1), 32'd1);
      chk("level", 32'(level), 32'(lev));
      chk("scan_idx", 32'(scan_idx), 32'((ecnt / TP) % NB));
      for (int i = 0; i < NB; i++) begin
        press_cnt[i] += int'(press[i]);
        rel_cnt[i] += int'(rel[i]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic wait_run(int b, int v, int budget);
    for (int k = 0; k < budget; k++) begin
      if (run[b] == v) break;
      step(1);
    end
    chk("wait_run_timeout", 32'(run[b]), 32'(v));
  endtask

  initial begin
    int bp, br, sidx;
    step(3);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_idx", 32'(scan_idx), 32'd0);
    reset_n = 1'b1;
    // idle scan
    bp = press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3];
    step(1000);
    chk("idle_pulses", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] - bp), 32'd0);
    // held press then release on button 0
    bp = press_cnt[0];
    br = rel_cnt[0];
    btn_raw[0] = 1'b1;
    step(3 * TP * NB + 40);
    chk("b0_press_once", 32'(press_cnt[0] - bp), 32'd1);
    chk("b0_level_hi", 32'(level[0]), 32'd1);
    btn_raw[0] = 1'b0;
    step(3 * TP * NB + 40);
    chk("b0_release_once", 32'(rel_cnt[0] - br), 32'd1);
    chk("b0_level_lo", 32'(level[0]), 32'd0);
    // fast chatter on button 2
    bp = press_cnt[2];
    br = rel_cnt[2];
    for (int k = 0; k < 100; k++) begin
      btn_raw[2] = ~btn_raw[2];
      step(5);
    end
    btn_raw[2] = 1'b0;
    step(10);
    chk("b2_chatter_press", 32'(press_cnt[2] - bp), 32'd0);
    chk("b2_chatter_release", 32'(rel_cnt[2] - br), 32'd0);
    // interrupted agreement on button 1
    bp = press_cnt[1];
    btn_raw[1] = 1'b1;
    wait_run(1, 2, 400);
    btn_raw[1] = 1'b0;
    wait_run(1, 0, 100);
    chk("b1_no_early_press", 32'(press_cnt[1] - bp), 32'd0);
    btn_raw[1] = 1'b1;
    wait_run(1, 2, 300);
    chk("b1_two_fresh", 32'(press_cnt[1] - bp), 32'd0);
    step(TP * NB + 6);
    chk("b1_third_fresh", 32'(press_cnt[1] - bp), 32'd1);
    // freeze during WAIT_HI on button 3
    bp = press_cnt[3];
    btn_raw[3] = 1'b1;
    wait_run(3, 1, 300);
    en = 1'b0;
    sidx = (ecnt / TP) % NB;
    step(200);
    chk("freeze_idx", 32'(scan_idx), 32'(sidx));
    chk("freeze_press", 32'(press_cnt[3] - bp), 32'd0);
    en = 1'b1;
    step(2 * TP * NB + 72);
    chk("resume_press", 32'(press_cnt[3] - bp), 32'd1);
    // reset mid-WAIT_HI on button 3
    btn_raw[3] = 1'b0;
    step(3 * TP * NB + 60);
    btn_raw[3] = 1'b1;
    wait_run(3, 2, 300);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_press", 32'(press | rel), 32'd0);
    chk("mid_rst_idx", 32'(scan_idx), 32'd0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    bp = press_cnt[3];
    wait_run(3, 2, 300);
    chk("post_rst_two", 32'(press_cnt[3] - bp), 32'd0);
    step(TP * NB + 6);
    chk("post_rst_third", 32'(press_cnt[3] - bp), 32'd1);
    // random slow buttons with occasional freezes
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 299) == 0) btn_raw[i] = ~btn_raw[i];
      if ($urandom_range(0, 59) == 0) en = ~en;
      step(1);
    end
    en = 1'b1;
    step(50);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
